// File: rtl/signed_mult_unit_pkg.sv
// Shared encodings for the iterative signed multiplier: FSM states and the
// handshake levels used between the execute stage and the multiplier.
package signed_mult_unit_pkg;

   typedef enum logic [1:0] {
      MULT_IDLE = 2'b00,
      MULT_CALC = 2'b01,
      MULT_DONE = 2'b10
   } mult_state_t;

   localparam logic MULT_START        = 1'b1;
   localparam logic MULT_STOP         = 1'b0;
   localparam logic MULT_FINISHED     = 1'b1;
   localparam logic MULT_NOT_FINISHED = 1'b0;

endpackage

// File: rtl/signed_mult_unit.sv
// Multi-cycle signed WIDTHxWIDTH multiplier: radix-2 shift-add on operand
// magnitudes, sign applied to the 2*WIDTH-bit product on the final step.
module signed_mult_unit
   import signed_mult_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mult_start,
   input  logic                 mult_cancel,
   input  logic [WIDTH-1:0]     signed_mult_op1,
   input  logic [WIDTH-1:0]     signed_mult_op2,
   output logic [2*WIDTH-1:0]   signed_mult_result,
   output logic                 mult_finished,
   output logic                 mult_busy
);

   mult_state_t        state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     acc;      // upper half plus carry bit
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;   // lower half of the product shifts in here
   logic               neg;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     acc_nxt;
   logic [WIDTH-1:0]   mplier_nxt;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] product_signed;
   logic [WIDTH-1:0]   abs_op1;
   logic [WIDTH-1:0]   abs_op2;

   // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is
   // still correct when read as unsigned.
   assign abs_op1 = signed_mult_op1[WIDTH-1] ? WIDTH'(0) - signed_mult_op1 : signed_mult_op1;
   assign abs_op2 = signed_mult_op2[WIDTH-1] ? WIDTH'(0) - signed_mult_op2 : signed_mult_op2;

   // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
   always_comb begin
      sum = acc;
      if (mplier[0])
         sum = acc + {1'b0, mcand};
      acc_nxt        = sum >> 1;
      mplier_nxt     = {sum[0], mplier[WIDTH-1:1]};
      product        = (2*WIDTH)'({acc_nxt, mplier_nxt});
      product_signed = neg ? ~product + 1'b1 : product;
   end

   // NOTE: state and datapath registers use non-blocking assignments so all
   // of them update together from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= MULT_IDLE;
         cnt                <= '0;
         acc                <= '0;
         mcand              <= '0;
         mplier             <= '0;
         neg                <= 1'b0;
         signed_mult_result <= '0;
         mult_finished      <= MULT_NOT_FINISHED;
         mult_busy          <= 1'b0;
      end else begin
         case (state)
            MULT_IDLE: begin
               mult_finished <= MULT_NOT_FINISHED;
               if (mult_start == MULT_START && !mult_cancel) begin
                  state     <= MULT_CALC;
                  mcand     <= abs_op1;
                  mplier    <= abs_op2;
                  neg       <= signed_mult_op1[WIDTH-1] ^ signed_mult_op2[WIDTH-1];
                  acc       <= '0;
                  cnt       <= '0;
                  mult_busy <= 1'b1;
               end
            end
            MULT_CALC: begin
               if (mult_cancel || mult_start == MULT_STOP) begin
                  state     <= MULT_IDLE;
                  mult_busy <= 1'b0;
               end else begin
                  acc    <= acc_nxt;
                  mplier <= mplier_nxt;
                  cnt    <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH-1)) begin
                     state              <= MULT_DONE;
                     signed_mult_result <= product_signed;
                     mult_finished      <= MULT_FINISHED;
                     mult_busy          <= 1'b0;
                  end
               end
            end
            MULT_DONE: begin
               state         <= MULT_IDLE;
               mult_finished <= MULT_NOT_FINISHED;
            end
            default: begin
               state         <= MULT_IDLE;
               mult_finished <= MULT_NOT_FINISHED;
               mult_busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/signed_mult_unit.md
Name: signed_mult_unit

Overview:
- Multi-cycle signed 32x32 multiplier that serves as the responder for the execute stage's signed-multiply handshake.
- The execute stage drives mult_start and the operands and stalls until mult_finished. This block then returns the 64-bit product, which the execute stage splits into hi/lo.
- Iterative radix-2 shift-add on operand magnitudes, with the sign applied at the end.
- Sits beside the execute stage in the core top level.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset; asynchronous, active-high.
- mult_start  input  1  request from the execute stage; held high while it stalls.
- mult_cancel  input  1  pipeline flush; aborts any operation in progress.
- signed_mult_op1  input  WIDTH  multiplicand, two's complement.
- signed_mult_op2  input  WIDTH  multiplier, two's complement.
- signed_mult_result  output  2*WIDTH  signed product, registered.
- mult_finished  output  1  one-cycle pulse; the result is valid in this cycle.
- mult_busy  output  1  high while in CALC (debug/perf).

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, internal accumulator/magnitudes=0, signed_mult_result=0, mult_finished=0, mult_busy=0.
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - DONE: result presented.
- IDLE → CALC on a clock edge where mult_start=1 and mult_cancel=0. On that edge:
  - latch |op1| and |op2| as unsigned WIDTH-bit values;
  - latch neg = op1[W-1] ^ op2[W-1];
  - clear the accumulator and set counter=0.
- Magnitude of -2^(W-1) is 2^(W-1), which fits in WIDTH unsigned bits. No extra bit is required.
- CALC, one step per cycle:
  - if multiplier bit0=1, add the multiplicand to the accumulator's upper half;
  - shift the {acc, multiplier} pair right by 1;
  - counter += 1.
- CALC → DONE after exactly WIDTH steps (counter==WIDTH-1 on the step edge). On that edge signed_mult_result is loaded with the product, negated (two's complement, 2*WIDTH bits) when neg=1.
- DONE lasts exactly one cycle:
  - mult_finished=1;
  - next edge → IDLE unconditionally.
- Latency: the first start cycle is C0; mult_finished is high in cycle C(WIDTH+1), i.e. C33 at default.
- No early-out for zero operands; the latency is fixed.
- mult_finished is a pulse. The execute stage drops mult_start combinationally in the DONE cycle and writes hi/lo at the end of it.
- A back-to-back multiply sees mult_finished=0 in the next IDLE cycle and restarts. Minimum gap between operations is one IDLE cycle.
- signed_mult_result holds its last value until the next DONE load. It is not cleared on start or cancel.
- Operands are sampled only on the IDLE→CALC edge. Later changes on op1/op2 are ignored.
- Abort: in CALC, mult_cancel=1 or mult_start=0 → IDLE on the next edge.
  - mult_finished is not asserted;
  - the result register is unchanged.
- mult_cancel in the DONE cycle: the pulse is still asserted (result already loaded); the state returns to IDLE as normal.
- Start and cancel both high in IDLE: stay in IDLE.
- rst asserted mid-CALC: immediate return to the reset values; no pulse.
- Arithmetic widths:
  - accumulator is WIDTH+1 bits, to hold the add carry;
  - product assembly is 2*WIDTH bits;
  - the negate is a full 2*WIDTH-bit increment.

Decomposition:
- defines.v gains:
  - MultIdle/MultCalc/MultDone state encodings (2 bits);
  - MultStart/MultStop and MultFinished/MultNotFinished constants;
  - DoubleRegBus (63:0).
- Existing RstEnable, ZeroWord and RegBus are reused.
- No sub-module. The block is a single FSM plus datapath, and the abs/negate logic is inline.

Test Plan:
- 7 x 6: start held with op1=7, op2=6 → finished pulse exactly 33 cycles after the start cycle, result=0x0000_0000_0000_002A, one cycle wide.
- (-3) x 5: op1=0xFFFFFFFD, op2=5 → result=0xFFFF_FFFF_FFFF_FFF1; (-3)x(-5) → 0x0000_0000_0000_000F.
- Extremes:
  - 0x80000000 x 0x80000000 → 0x4000_0000_0000_0000;
  - 0x80000000 x 0x7FFFFFFF → 0xC000_0000_8000_0000;
  - 0 x 0xFFFFFFFF → 0, still 33 cycles.
- Abort: start, then cancel at cycle 10 → no finished pulse, result keeps its prior value. A new start afterwards completes correctly in 33 cycles.
- Operand stability: change op1/op2 during CALC → result reflects the values latched at start. Back-to-back: two multiplies with start re-raised the cycle after DONE → both results correct, pulses 34 cycles apart.
- Reset: assert rst asynchronously mid-CALC (between edges) → outputs go to 0 immediately; after release no pulse until a new start.
